// File: rtl/ai_decompressor_param.sv
// Parametrised feature decompressor: raw passthrough plus
// anchor-based sample reconstruction with valid/ready flow control.
module ai_decompressor_param #(
  parameter int SW               = 8,
  parameter int NRAW             = 4,
  parameter int NOUT             = 4,
  parameter int IW               = 64,
  parameter bit ANCHOR_LSB_CLEAR = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init,
  input  logic                       compress,
  input  logic [IW-1:0]              in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [(NOUT+NRAW)*SW-1:0]  out_data,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int L  = $clog2(NOUT);
  localparam int W2 = SW + L + 1;
  localparam int B  = 2 + 3 * SW;
  localparam int RW = NRAW * SW;
  localparam int OW = (NOUT + NRAW) * SW;
  localparam logic [SW-1:0] AMASK =
    {{(SW-1){1'b1}}, ~ANCHOR_LSB_CLEAR};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    EMIT
  } state_t;

  state_t          state;
  logic [1:0]      mode_q;
  logic [SW-1:0]   last_q;
  logic [SW-1:0]   act_q;
  logic [SW-1:0]   next_q;
  logic [SW-1:0]   d1_q;
  logic [SW-1:0]   d2_q;
  logic            m1_q;
  logic            m2_q;
  logic [RW-1:0]   raw_q;

  logic [SW-1:0]   last_w;
  logic [SW-1:0]   act_w;
  logic [SW-1:0]   next_w;
  logic [OW-1:0]   calc_w;

  logic [W2-1:0]   d1e;
  logic [W2-1:0]   d2e;
  logic [W2-1:0]   base_v;
  logic [W2-1:0]   term_v;
  logic [W2-1:0]   sum_v;
  logic            neg_v;
  logic            hold_v;

  assign in_ready = (state == IDLE);

  assign last_w = in_data[SW+1:2] & AMASK;
  assign act_w  = in_data[2*SW+1:SW+2] & AMASK;
  assign next_w = in_data[3*SW+1:2*SW+2] & AMASK;

  generate
    if (IW > B + RW) begin : g_spare
      logic unused_msbs;
      assign unused_msbs = ^in_data[IW-1:B+RW];
    end
  endgenerate

  assign d1e = W2'(d1_q);
  assign d2e = W2'(d2_q);

  always_comb begin
    calc_w = '0;
    base_v = '0;
    term_v = '0;
    sum_v  = '0;
    neg_v  = 1'b0;
    hold_v = 1'b0;
    for (int k = 0; k < NOUT; k++) begin
      base_v = W2'(last_q);
      neg_v  = m1_q;
      term_v = '0;
      hold_v = 1'b0;
      unique case (mode_q)
        2'd0: term_v = (d1e * W2'(k + 1)) >> L;
        2'd1: begin
          if (k == NOUT - 1) begin
            hold_v = 1'b1;
          end else begin
            for (int j = 1; j <= k + 1; j++)
              term_v = term_v + (d1e >> j);
          end
        end
        2'd2: begin
          if (k < NOUT / 2 - 1) begin
            term_v = (d1e * W2'(k + 1)) >> (L - 1);
          end else if (k == NOUT / 2 - 1) begin
            hold_v = 1'b1;
          end else begin
            base_v = W2'(act_q);
            neg_v  = m2_q;
            term_v = d2e >> (NOUT + 2 - k);
          end
        end
        default: hold_v = 1'b1;
      endcase
      sum_v = neg_v ? base_v - term_v : base_v + term_v;
      calc_w[OW-1-k*SW -: SW] = hold_v ? act_q : sum_v[SW-1:0];
    end
    calc_w[RW-1:0] = raw_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      mode_q    <= '0;
      last_q    <= '0;
      act_q     <= '0;
      next_q    <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
      m1_q      <= 1'b0;
      m2_q      <= 1'b0;
      raw_q     <= '0;
    end else if (init) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && compress) begin
            mode_q <= in_data[1:0];
            last_q <= last_w;
            act_q  <= act_w;
            next_q <= next_w;
            raw_q  <= in_data[B+RW-1:B];
            m1_q   <= act_w < last_w;
            m2_q   <= next_w < act_w;
            d1_q   <= (act_w < last_w) ? last_w - act_w
                                       : act_w - last_w;
            d2_q   <= (next_w < act_w) ? act_w - next_w
                                       : next_w - act_w;
            state  <= CALC;
          end
        end
        CALC: begin
          out_data  <= calc_w;
          out_valid <= 1'b1;
          state     <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
